// File: rtl/data_mem_access_unit.sv
// data_mem_access_unit
// Executes Control's load/store requests on a req/ack data-memory bus.
// Produces byte enables and lane-replicated store data. Extracts and
// sign/zero-extends load data. Holds the pipeline until the access completes.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned H/W accesses
// without touching the bus. Otherwise the offending low address bits are ignored.
module data_mem_access_unit #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        iCLK,
  input  logic        iRSTn,
  input  logic        iMemRead,
  input  logic        iMemWrite,
  input  logic [2:0]  iFunct3,
  input  logic [31:0] iAddr,
  input  logic [31:0] iWData,
  output logic [31:0] oRData,
  output logic        oStall,
  output logic        oDone,
  output logic        oBusErr,
  output logic        oMisalign,
  output logic        oBusReq,
  output logic        oBusWE,
  output logic [31:0] oBusAddr,
  output logic [3:0]  oBusBE,
  output logic [31:0] oBusWData,
  input  logic        iBusAck,
  input  logic [31:0] iBusRData
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  // The counter only needs to reach TIMEOUT_CYC-1. A zero timeout disables the compare.
  localparam int unsigned LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam int unsigned CW   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LAST);

  state_t      state_q;
  logic [CW-1:0] cnt_q;
  logic        req_in;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [1:0]  alo_q;
  logic [2:0]  funct3_q;
  logic [31:0] load_ext;
  logic [31:0] rdata_q;
  logic        done_q;
  logic        err_q;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;

  assign req_in = iMemRead | iMemWrite;

  // Byte enables and replicated store data for the requested size
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = iWData;
    if (iFunct3[1:0] == 2'b00) begin
      be_d    = 4'b0001 << iAddr[1:0];
      wdata_d = {4{iWData[7:0]}};
    end else if (iFunct3[1:0] == 2'b01) begin
      be_d    = 4'b0011 << {iAddr[1], 1'b0};
      wdata_d = {2{iWData[15:0]}};
    end
  end

  // Load lane extraction and extension from the captured address and size
  always_comb begin
    logic [1:0]  lane;
    logic [31:0] shifted;
    lane = 2'b00;
    if (funct3_q[1:0] == 2'b00)      lane = alo_q;
    else if (funct3_q[1:0] == 2'b01) lane = {alo_q[1], 1'b0};
    shifted  = iBusRData >> {lane, 3'b000};
    load_ext = shifted;
    if (funct3_q[1:0] == 2'b00)
      load_ext = funct3_q[2] ? {24'h0, shifted[7:0]}
                             : {{24{shifted[7]}}, shifted[7:0]};
    else if (funct3_q[1:0] == 2'b01)
      load_ext = funct3_q[2] ? {16'h0, shifted[15:0]}
                             : {{16{shifted[15]}}, shifted[15:0]};
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign_in;
  logic mis_q;

  // Misalignment of the incoming request: H on an odd byte, W off a word boundary
  always_comb begin
    misalign_in = 1'b0;
    if (iFunct3[1:0] == 2'b01)      misalign_in = iAddr[0];
    else if (iFunct3[1:0] != 2'b00) misalign_in = |iAddr[1:0];
  end
`endif

  // Access sequencer: IDLE -> REQ -> DONE/ERR -> IDLE, all outputs registered
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      alo_q    <= '0;
      funct3_q <= '0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
`ifdef MISALIGN_TRAP_EN
      mis_q    <= 1'b0;
`endif
    end else begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
`ifdef MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (req_in) begin
`ifdef MISALIGN_TRAP_EN
            if (misalign_in) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              mis_q   <= 1'b1;
            end else
`endif
            begin
              state_q  <= REQ;
              cnt_q    <= '0;
              req_q    <= 1'b1;
              we_q     <= iMemWrite;
              addr_q   <= {iAddr[31:2], 2'b00};
              be_q     <= be_d;
              wdata_q  <= wdata_d;
              alo_q    <= iAddr[1:0];
              funct3_q <= iFunct3;
            end
          end
        end
        REQ: begin
          // An ack on the same edge as the final count wins over the timeout.
          if (iBusAck) begin
            state_q <= DONE;
            req_q   <= 1'b0;
            done_q  <= 1'b1;
            rdata_q <= load_ext;
          end else if ((TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST)) begin
            state_q <= ERR;
            req_q   <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stall is combinational in IDLE so the request cycle itself is held.
  // It is forced low while reset is asserted.
  assign oStall    = iRSTn & (((state_q == IDLE) & req_in) | (state_q == REQ));
  assign oRData    = rdata_q;
  assign oDone     = done_q;
  assign oBusErr   = err_q;
  assign oBusReq   = req_q;
  assign oBusWE    = we_q;
  assign oBusAddr  = addr_q;
  assign oBusBE    = be_q;
  assign oBusWData = wdata_q;
`ifdef MISALIGN_TRAP_EN
  assign oMisalign = mis_q;
`else
  assign oMisalign = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Testbench for data_mem_access_unit: table-driven accesses with a scoreboard,
// plus hand sequences for misalignment, timeout and mid-access reset.
module tb_data_mem_access_unit;

  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_rd, mem_wr;
  logic [2:0]  f3;
  logic [31:0] addr, wdata;
  logic [31:0] o_rdata;
  logic        o_stall, o_done, o_buserr, o_mis, o_req, o_we;
  logic [31:0] o_addr, o_wdata;
  logic [3:0]  o_be;
  logic        ack;
  logic [31:0] bus_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  data_mem_access_unit #(.TIMEOUT_CYC(TMO)) dut (
    .iCLK(clk), .iRSTn(rst_n), .iMemRead(mem_rd), .iMemWrite(mem_wr),
    .iFunct3(f3), .iAddr(addr), .iWData(wdata), .oRData(o_rdata),
    .oStall(o_stall), .oDone(o_done), .oBusErr(o_buserr), .oMisalign(o_mis),
    .oBusReq(o_req), .oBusWE(o_we), .oBusAddr(o_addr), .oBusBE(o_be),
    .oBusWData(o_wdata), .iBusAck(ack), .iBusRData(bus_rdata)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int unsigned wt;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    int unsigned lat;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] fn,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rdv, input int unsigned wt,
                              input logic [31:0] ea, input logic [3:0] ebe,
                              input logic [31:0] ewd, input logic [31:0] erd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = fn; v.addr = a; v.wdata = wd; v.rdata = rdv;
    v.wt = wt; v.e_addr = ea; v.e_be = ebe; v.e_wdata = ewd; v.e_rdata = erd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // One complete access: drive, answer the bus after v.wt wait cycles, check result
  task automatic run_vec(input vec_t v);
    int unsigned cyc;
    int unsigned r;
    bit got;
    exp_t e;
    logic [68:0] first;
    @(negedge clk);
    mem_rd = v.rd; mem_wr = v.wr; f3 = v.f3; addr = v.addr; wdata = v.wdata;
    ack = 1'b0;
    e.err   = (v.wt >= TMO);
    e.lat   = e.err ? TMO + 2 : v.wt + 3;
    e.rdata = e.err ? 32'h0 : v.e_rdata;
    sb.push_back(e);
    #1 chk("stall_idle", {31'h0, o_stall}, 32'h1);
    cyc = 1; r = 0; got = 1'b0; first = '0;
    while (!got && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (o_done) begin
        got = 1'b1;
      end else begin
        chk("busreq", {31'h0, o_req}, 32'h1);
        chk("stall_req", {31'h0, o_stall}, 32'h1);
        if (r == 0) begin
          chk("bus_addr", o_addr, v.e_addr);
          chk("bus_be", {28'h0, o_be}, {28'h0, v.e_be});
          chk("bus_wdata", o_wdata, v.e_wdata);
          chk("bus_we", {31'h0, o_we}, {31'h0, v.wr});
          first = {o_addr, o_be, o_wdata, o_we};
        end else begin
          chk("bus_stable", {31'h0, ({o_addr, o_be, o_wdata, o_we} == first)}, 32'h1);
        end
        ack = (r == v.wt);
        bus_rdata = (r == v.wt) ? v.rdata : $urandom();
        r++;
      end
    end
    ack = 1'b0;
    mem_rd = 1'b0; mem_wr = 1'b0;
    e = sb.pop_front();
    if (!got) begin
      chk("done_seen", 32'h0, 32'h1);
    end else begin
      chk("latency", cyc, e.lat);
      chk("rdata", o_rdata, e.rdata);
      chk("buserr", {31'h0, o_buserr}, {31'h0, e.err});
      chk("misalign", {31'h0, o_mis}, 32'h0);
      chk("stall_done", {31'h0, o_stall}, 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; f3 = '0; addr = '0; wdata = '0;
    ack = 1'b0; bus_rdata = '0;

    //         rd  wr  f3      addr          wdata         rdata         wt  e_addr        be       e_wdata       e_rdata
    vecs.push_back(mk(1, 0, 3'b010, 32'h0000_1004, 32'h0,         32'hDEAD_BEEF, 0,  32'h0000_1004, 4'b1111, 32'h0,         32'hDEAD_BEEF));
    vecs.push_back(mk(0, 1, 3'b000, 32'h0000_2003, 32'h0000_00A5, 32'h0,         0,  32'h0000_2000, 4'b1000, 32'hA5A5_A5A5, 32'h0));
    vecs.push_back(mk(1, 0, 3'b000, 32'h0000_3002, 32'h0,         32'h0080_0000, 0,  32'h0000_3000, 4'b0100, 32'h0,         32'hFFFF_FF80));
    vecs.push_back(mk(1, 0, 3'b100, 32'h0000_3002, 32'h0,         32'h0080_0000, 1,  32'h0000_3000, 4'b0100, 32'h0,         32'h0000_0080));
    vecs.push_back(mk(1, 0, 3'b001, 32'h0000_3002, 32'h0,         32'h8001_0000, 0,  32'h0000_3000, 4'b1100, 32'h0,         32'hFFFF_8001));
    vecs.push_back(mk(1, 0, 3'b101, 32'h0000_3000, 32'h0,         32'h1234_F00D, 0,  32'h0000_3000, 4'b0011, 32'h0,         32'h0000_F00D));
    vecs.push_back(mk(1, 0, 3'b010, 32'h0000_0040, 32'h0,         32'h0BAD_F00D, 5,  32'h0000_0040, 4'b1111, 32'h0,         32'h0BAD_F00D));
    vecs.push_back(mk(0, 1, 3'b010, 32'h0000_5008, 32'h1234_5678, 32'h0,         2,  32'h0000_5008, 4'b1111, 32'h1234_5678, 32'h0));
    vecs.push_back(mk(1, 0, 3'b000, 32'h0000_0007, 32'h0,         32'h7F00_0000, 0,  32'h0000_0004, 4'b1000, 32'h0,         32'h0000_007F));
    vecs.push_back(mk(1, 0, 3'b111, 32'h0000_0010, 32'h0,         32'hCAFE_BABE, 0,  32'h0000_0010, 4'b1111, 32'h0,         32'hCAFE_BABE));
    vecs.push_back(mk(1, 0, 3'b010, 32'h0000_0020, 32'h0,         32'h55AA_55AA, 15, 32'h0000_0020, 4'b1111, 32'h0,         32'h55AA_55AA));
    vecs.push_back(mk(1, 1, 3'b001, 32'h0000_6002, 32'hFFFF_1234, 32'h0,         0,  32'h0000_6000, 4'b1100, 32'h1234_1234, 32'h0));
    vecs.push_back(mk(0, 1, 3'b001, 32'h0000_8000, 32'h0000_BEEF, 32'h0,         1,  32'h0000_8000, 4'b0011, 32'hBEEF_BEEF, 32'h0));
    vecs.push_back(mk(1, 0, 3'b010, 32'h0000_0100, 32'h0,         32'h0,         99, 32'h0000_0100, 4'b1111, 32'h0,         32'h0));

    // Reset state
    @(negedge clk);
    chk("rst_req", {31'h0, o_req}, 32'h0);
    chk("rst_stall", {31'h0, o_stall}, 32'h0);
    chk("rst_done", {31'h0, o_done}, 32'h0);
    chk("rst_rdata", o_rdata, 32'h0);
    chk("rst_addr", o_addr, 32'h0);
    chk("rst_be", {28'h0, o_be}, 32'h0);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Misaligned halfword store
`ifdef MISALIGN_TRAP_EN
    begin
      int unsigned cyc;
      bit got;
      bit saw_req;
      @(negedge clk);
      mem_rd = 1'b0; mem_wr = 1'b1; f3 = 3'b001; addr = 32'h0000_1001; wdata = 32'h0000_BEEF;
      cyc = 1; got = 1'b0; saw_req = 1'b0;
      while (!got && cyc < 10) begin
        @(negedge clk);
        cyc++;
        if (o_req) saw_req = 1'b1;
        if (o_done) got = 1'b1;
      end
      mem_wr = 1'b0;
      chk("mis_latency", cyc, 32'd2);
      chk("mis_flag", {31'h0, o_mis}, 32'h1);
      chk("mis_rdata", o_rdata, 32'h0);
      chk("mis_noreq", {31'h0, saw_req}, 32'h0);
    end
`else
    run_vec(mk(0, 1, 3'b001, 32'h0000_1001, 32'h0000_BEEF, 32'h0, 0,
               32'h0000_1000, 4'b0011, 32'hBEEF_BEEF, 32'h0));
`endif

    // Reset in the middle of a bus request
    @(negedge clk);
    mem_rd = 1'b1; mem_wr = 1'b0; f3 = 3'b010; addr = 32'h0000_0200; ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_req", {31'h0, o_req}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_req", {31'h0, o_req}, 32'h0);
    chk("async_stall", {31'h0, o_stall}, 32'h0);
    @(negedge clk);
    mem_rd = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("no_retry_req", {31'h0, o_req}, 32'h0);
      chk("no_retry_done", {31'h0, o_done}, 32'h0);
    end
    run_vec(mk(1, 0, 3'b010, 32'h0000_1004, 32'h0, 32'h1357_9BDF, 0,
               32'h0000_1004, 4'b1111, 32'h0, 32'h1357_9BDF));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
